// File: rtl/friscv_io_master_pkg.sv
// Shared types for the IO bus initiator: FSM states and the
// buffered request entry.
package friscv_io_master_pkg;

    localparam int IO_ADDRW = 15;
    localparam int IO_XLEN  = 32;
    localparam int IO_STRBW = IO_XLEN / 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } io_state_t;

    typedef struct packed {
        logic                wr;
        logic [IO_ADDRW-1:0] addr;
        logic [IO_XLEN-1:0]  wdata;
        logic [IO_STRBW-1:0] strb;
    } io_req_t;

endpackage

// File: rtl/friscv_io_req_fifo.sv
// Single-clock request buffer between the load/store unit and the
// IO access sequencer.
module friscv_io_req_fifo
    import friscv_io_master_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    aclk,
    input  logic    srst,
    input  logic    push,
    input  io_req_t wdata,
    input  logic    pop,
    output io_req_t rdata,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    // Extra MSB on each pointer separates the full and empty cases.
    logic [AW:0] wptr_q;
    logic [AW:0] wptr_d;
    logic [AW:0] rptr_q;
    logic [AW:0] rptr_d;
    io_req_t     mem_q [DEPTH];

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push && !full) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (pop && !empty) begin
            rptr_d = rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (push && !full) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/friscv_io_master.sv
// IO bus initiator: buffers load/store requests and issues them one at
// a time, with a watchdog that errors out unacknowledged accesses.
module friscv_io_master
    import friscv_io_master_pkg::*;
#(
    parameter int ADDRW   = IO_ADDRW,
    parameter int XLEN    = IO_XLEN,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              aclk,
    input  logic              srst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDRW-1:0]  req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [XLEN/8-1:0] req_strb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              mst_en,
    output logic              mst_wr,
    output logic [ADDRW-1:0]  mst_addr,
    output logic [XLEN-1:0]   mst_wdata,
    output logic [XLEN/8-1:0] mst_strb,
    input  logic [XLEN-1:0]   mst_rdata,
    input  logic              mst_ready
);

    localparam int WDW = $clog2(TIMEOUT);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    localparam logic [WDW-1:0] WD_ONE  = WDW'(1);

    io_state_t         state_q;
    io_state_t         state_d;
    logic              mst_en_q;
    logic              mst_en_d;
    logic              mst_wr_q;
    logic              mst_wr_d;
    logic [ADDRW-1:0]  mst_addr_q;
    logic [ADDRW-1:0]  mst_addr_d;
    logic [XLEN-1:0]   mst_wdata_q;
    logic [XLEN-1:0]   mst_wdata_d;
    logic [XLEN/8-1:0] mst_strb_q;
    logic [XLEN/8-1:0] mst_strb_d;
    logic              rsp_valid_q;
    logic              rsp_valid_d;
    logic [XLEN-1:0]   rsp_rdata_q;
    logic [XLEN-1:0]   rsp_rdata_d;
    logic              rsp_err_q;
    logic              rsp_err_d;
    logic [WDW-1:0]    wdog_q;
    logic [WDW-1:0]    wdog_d;

    logic    fifo_full;
    logic    fifo_empty;
    logic    fifo_push;
    logic    fifo_pop;
    io_req_t push_data;
    io_req_t head;

    assign req_ready = !fifo_full && !srst;
    assign fifo_push = req_valid && req_ready;
    assign push_data = '{wr: req_wr, addr: req_addr,
                         wdata: req_wdata, strb: req_strb};

    friscv_io_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .aclk  (aclk),
        .srst  (srst),
        .push  (fifo_push),
        .wdata (push_data),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        mst_en_d    = mst_en_q;
        mst_wr_d    = mst_wr_q;
        mst_addr_d  = mst_addr_q;
        mst_wdata_d = mst_wdata_q;
        mst_strb_d  = mst_strb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        wdog_d      = wdog_q;
        fifo_pop    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    mst_en_d    = 1'b1;
                    mst_wr_d    = head.wr;
                    mst_addr_d  = head.addr;
                    mst_wdata_d = head.wdata;
                    mst_strb_d  = head.strb;
                    wdog_d      = '0;
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Acknowledge takes priority over the watchdog expiring.
                if (mst_ready) begin
                    rsp_rdata_d = mst_wr_q ? '0 : mst_rdata;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    mst_en_d    = 1'b0;
                    fifo_pop    = 1'b1;
                    state_d     = ST_RESP;
                end else if (wdog_q == WD_LAST) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    mst_en_d    = 1'b0;
                    fifo_pop    = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    wdog_d = wdog_q + WD_ONE;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            state_q     <= ST_IDLE;
            mst_en_q    <= 1'b0;
            mst_wr_q    <= 1'b0;
            mst_addr_q  <= '0;
            mst_wdata_q <= '0;
            mst_strb_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            mst_en_q    <= mst_en_d;
            mst_wr_q    <= mst_wr_d;
            mst_addr_q  <= mst_addr_d;
            mst_wdata_q <= mst_wdata_d;
            mst_strb_q  <= mst_strb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            wdog_q      <= wdog_d;
        end
    end

    assign mst_en    = mst_en_q;
    assign mst_wr    = mst_wr_q;
    assign mst_addr  = mst_addr_q;
    assign mst_wdata = mst_wdata_q;
    assign mst_strb  = mst_strb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_friscv_io_master.sv
// Bench for friscv_io_master: directed scenarios plus a randomized
// stream checked against an in-order transaction model.
module tb_friscv_io_master;

    localparam int ADDRW   = 15;
    localparam int XLEN    = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;
    localparam int NEVER   = 100000;

    logic              aclk = 1'b0;
    logic              srst;
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDRW-1:0]  req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [XLEN/8-1:0] req_strb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;
    logic              mst_en;
    logic              mst_wr;
    logic [ADDRW-1:0]  mst_addr;
    logic [XLEN-1:0]   mst_wdata;
    logic [XLEN/8-1:0] mst_strb;
    logic [XLEN-1:0]   mst_rdata;
    logic              mst_ready;

    always #5 aclk = ~aclk;

    friscv_io_master #(
        .ADDRW   (ADDRW),
        .XLEN    (XLEN),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .aclk      (aclk),
        .srst      (srst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .mst_en    (mst_en),
        .mst_wr    (mst_wr),
        .mst_addr  (mst_addr),
        .mst_wdata (mst_wdata),
        .mst_strb  (mst_strb),
        .mst_rdata (mst_rdata),
        .mst_ready (mst_ready)
    );

    // One planned transaction: request fields plus how the slave behaves
    // (ready after wt cycles of mst_en, returning rdata).
    typedef struct {
        logic             wr;
        logic [ADDRW-1:0] addr;
        logic [XLEN-1:0]  wdata;
        logic [3:0]       strb;
        int               wt;
        logic [XLEN-1:0]  rdata;
    } acc_t;

    acc_t plan_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic acc_t mk(logic wr, logic [ADDRW-1:0] addr,
                                logic [XLEN-1:0] wd, logic [3:0] strb,
                                int wt, logic [XLEN-1:0] rd);
        acc_t a;
        a.wr = wr;
        a.addr = addr;
        a.wdata = wd;
        a.strb = strb;
        a.wt = wt;
        a.rdata = rd;
        return a;
    endfunction

    // Slave model: raises ready once the access has lasted wt+1 cycles.
    initial begin : responder
        acc_t cur;
        bit   active;
        int   cnt;
        mst_ready = 1'b0;
        mst_rdata = '0;
        active = 1'b0;
        cnt = 0;
        cur = mk(1'b0, '0, '0, '0, NEVER, '0);
        forever begin
            tick();
            if (mst_en !== 1'b1) begin
                active = 1'b0;
                mst_ready = 1'b0;
                mst_rdata = '0;
            end else begin
                if (!active) begin
                    active = 1'b1;
                    cnt = 0;
                    if (plan_q.size() > 0) cur = plan_q.pop_front();
                    else cur.wt = NEVER;
                end else begin
                    cnt++;
                end
                if (cnt >= cur.wt) begin
                    mst_ready = 1'b1;
                    mst_rdata = cur.rdata;
                end else begin
                    mst_ready = 1'b0;
                    mst_rdata = $urandom();
                end
            end
        end
    end

    task automatic push_one(input acc_t a, output bit ok);
        ok = 1'b0;
        req_wr = a.wr;
        req_addr = a.addr;
        req_wdata = a.wdata;
        req_strb = a.strb;
        req_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (req_ready === 1'b1) begin
                plan_q.push_back(a);
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (rsp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    function automatic int pick_wait();
        int r;
        r = int'($urandom_range(0, 9));
        if (r <= 5) return r % 4;
        if (r == 6) return TIMEOUT - 2;
        if (r == 7) return TIMEOUT - 1;
        if (r == 8) return TIMEOUT;
        return NEVER;
    endfunction

    task automatic test_reset();
        srst = 1'b1;
        req_valid = 1'b1;
        req_wr = 1'b1;
        req_addr = 15'h7;
        req_wdata = 32'h1111_2222;
        req_strb = 4'h3;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if (mst_en !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold cyc %0d: en=%b rv=%b rr=%b, want 0 0 0",
                         i, mst_en, rsp_valid, req_ready);
            end
        end
        n_tests++;
        if ({mst_wr, mst_addr, mst_wdata, mst_strb, rsp_rdata, rsp_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: wr=%b addr=%h wd=%h strb=%h rd=%h err=%b, want all 0",
                     mst_wr, mst_addr, mst_wdata, mst_strb, rsp_rdata, rsp_err);
        end
        srst = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        #1;
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: req_ready=%b, want 1", req_ready);
        end
        repeat (3) tick();
        n_tests++;
        if (mst_en !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_empty: en=%b rv=%b, want 0 0", mst_en, rsp_valid);
        end
    endtask

    task automatic test_write();
        acc_t a;
        bit   ok;
        int   cnt;
        a = mk(1'b1, 15'h0, 32'h0987_6543, 4'hF, 3, 32'hdead_beef);
        push_one(a, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL write_accept: not accepted, want accepted");
        end
        n_tests++;
        if (mst_en !== 1'b0) begin
            n_fail++;
            $display("FAIL write_early: mst_en=%b one cycle after accept, want 0", mst_en);
        end
        tick();
        n_tests++;
        if (mst_en !== 1'b1) begin
            n_fail++;
            $display("FAIL write_latency: mst_en=%b two cycles after accept, want 1", mst_en);
        end
        cnt = 0;
        while (mst_en === 1'b1 && cnt < 200) begin
            n_tests++;
            if ({mst_wr, mst_addr, mst_wdata, mst_strb} !==
                {1'b1, 15'h0, 32'h0987_6543, 4'hF}) begin
                n_fail++;
                $display("FAIL write_stable: wr=%b addr=%h wd=%h strb=%h, want 1 0 09876543 f",
                         mst_wr, mst_addr, mst_wdata, mst_strb);
            end
            cnt++;
            tick();
        end
        n_tests++;
        if (cnt != 4) begin
            n_fail++;
            $display("FAIL write_len: mst_en high %0d cycles, want 4", cnt);
        end
        repeat (2) begin
            n_tests++;
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== '0) begin
                n_fail++;
                $display("FAIL write_rsp: rv=%b err=%b rd=%h, want 1 0 0",
                         rsp_valid, rsp_err, rsp_rdata);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        repeat (4) tick();
        n_tests++;
        if (rsp_valid !== 1'b0 || mst_en !== 1'b0) begin
            n_fail++;
            $display("FAIL write_single: rv=%b en=%b after handshake, want 0 0",
                     rsp_valid, mst_en);
        end
    endtask

    task automatic test_read();
        acc_t a;
        bit   ok;
        int   cnt;
        a = mk(1'b0, 15'h1, $urandom(), 4'hF, 0, 32'ha5a5_a5a5);
        push_one(a, ok);
        tick();
        cnt = 0;
        while (mst_en === 1'b1 && cnt < 200) begin
            n_tests++;
            if (mst_wr !== 1'b0 || mst_addr !== 15'h1) begin
                n_fail++;
                $display("FAIL read_req: wr=%b addr=%h, want 0 1", mst_wr, mst_addr);
            end
            cnt++;
            tick();
        end
        n_tests++;
        if (!ok || cnt != 1) begin
            n_fail++;
            $display("FAIL read_len: accepted=%b len=%0d, want 1 1", ok, cnt);
        end
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'ha5a5_a5a5) begin
            n_fail++;
            $display("FAIL read_rsp: rv=%b err=%b rd=%h, want 1 0 a5a5a5a5",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_unmapped();
        acc_t a;
        acc_t b;
        bit   ok;
        int   cnt;
        a = mk(1'b0, 15'h1000, '0, 4'hF, NEVER, 32'hffff_ffff);
        b = mk(1'b0, 15'h2, '0, 4'hF, 2, 32'h1234_5678);
        push_one(a, ok);
        push_one(b, ok);
        for (int i = 0; i < 20 && mst_en !== 1'b1; i++) tick();
        cnt = 0;
        while (mst_en === 1'b1 && cnt < 200) begin
            cnt++;
            tick();
        end
        n_tests++;
        if (cnt != TIMEOUT) begin
            n_fail++;
            $display("FAIL unmapped_len: mst_en high %0d cycles, want %0d", cnt, TIMEOUT);
        end
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== '0) begin
            n_fail++;
            $display("FAIL unmapped_rsp: rv=%b err=%b rd=%h, want 1 1 0",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        wait_rsp(ok);
        n_tests++;
        if (!ok || rsp_err !== 1'b0 || rsp_rdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL unmapped_next: seen=%b err=%b rd=%h, want 1 0 12345678",
                     ok, rsp_err, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // Stream engine: pushes n requests, checks each access and each
    // response in order against the planned transactions.
    task automatic run_stream(input int n, input int hold, input bit rnd);
        acc_t acc_q[$];
        acc_t rsp_q[$];
        int   limit;
        limit = n * 200 + hold + 100;
        fork
            begin : pusher
                for (int i = 0; i < n; i++) begin
                    acc_t a;
                    bit   ok;
                    a.wr = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                    a.addr = 15'($urandom());
                    a.wdata = $urandom();
                    a.strb = 4'($urandom());
                    a.rdata = $urandom();
                    a.wt = rnd ? pick_wait() : ((i == 0) ? 8 : 0);
                    if (rnd) repeat ($urandom_range(0, 2)) tick();
                    push_one(a, ok);
                    n_tests++;
                    if (!ok) begin
                        n_fail++;
                        $display("FAIL stream_accept #%0d: not accepted, want accepted", i);
                    end else begin
                        acc_q.push_back(a);
                        rsp_q.push_back(a);
                    end
                    if (!rnd && i == DEPTH - 1) begin
                        n_tests++;
                        if (req_ready !== 1'b0) begin
                            n_fail++;
                            $display("FAIL bp_full: req_ready=%b after %0d accepted, want 0",
                                     req_ready, DEPTH);
                        end
                    end
                end
            end
            begin : monitor
                bit prev;
                int seen;
                prev = 1'b0;
                seen = 0;
                for (int c = 0; c < limit && seen < n; c++) begin
                    tick();
                    if (mst_en === 1'b1 && !prev) begin
                        acc_t e;
                        n_tests++;
                        if (acc_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL stream_access: unexpected access addr=%h", mst_addr);
                        end else begin
                            e = acc_q.pop_front();
                            if ({mst_wr, mst_addr, mst_wdata, mst_strb} !==
                                {e.wr, e.addr, e.wdata, e.strb}) begin
                                n_fail++;
                                $display("FAIL stream_access: got %b %h %h %h, want %b %h %h %h",
                                         mst_wr, mst_addr, mst_wdata, mst_strb,
                                         e.wr, e.addr, e.wdata, e.strb);
                            end
                        end
                        seen++;
                    end
                    prev = (mst_en === 1'b1);
                end
                n_tests++;
                if (seen != n) begin
                    n_fail++;
                    $display("FAIL stream_access_count: got %0d, want %0d", seen, n);
                end
            end
            begin : consumer
                int got;
                got = 0;
                for (int c = 0; c < limit && got < n; c++) begin
                    rsp_ready = (c >= hold) && (!rnd || $urandom_range(0, 3) != 0);
                    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                        acc_t        e;
                        logic        x_err;
                        logic [31:0] x_rd;
                        n_tests++;
                        if (rsp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL stream_rsp: unexpected response");
                        end else begin
                            e = rsp_q.pop_front();
                            x_err = (e.wt >= TIMEOUT);
                            x_rd = (x_err || e.wr) ? 32'h0 : e.rdata;
                            if (rsp_err !== x_err || rsp_rdata !== x_rd) begin
                                n_fail++;
                                $display("FAIL stream_rsp addr=%h: err=%b rd=%h, want %b %h",
                                         e.addr, rsp_err, rsp_rdata, x_err, x_rd);
                            end
                        end
                        got++;
                    end
                    tick();
                end
                rsp_ready = 1'b0;
                n_tests++;
                if (got != n) begin
                    n_fail++;
                    $display("FAIL stream_rsp_count: got %0d, want %0d", got, n);
                end
            end
        join
    endtask

    task automatic test_backpressure();
        run_stream(6, 25, 1'b0);
    endtask

    task automatic test_random();
        run_stream(24, 0, 1'b1);
    endtask

    task automatic test_reset_mid();
        acc_t a;
        bit   ok;
        push_one(mk(1'b0, 15'h10, '0, 4'hF, NEVER, '0), ok);
        push_one(mk(1'b1, 15'h11, $urandom(), 4'hF, 0, '0), ok);
        push_one(mk(1'b0, 15'h12, '0, 4'hF, 0, $urandom()), ok);
        n_tests++;
        if (mst_en !== 1'b1 || mst_addr !== 15'h10) begin
            n_fail++;
            $display("FAIL rstmid_access: en=%b addr=%h, want 1 0010", mst_en, mst_addr);
        end
        srst = 1'b1;
        tick();
        n_tests++;
        if (mst_en !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_drop: en=%b rv=%b rr=%b, want 0 0 0",
                     mst_en, rsp_valid, req_ready);
        end
        srst = 1'b0;
        plan_q.delete();
        #1;
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (mst_en !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rstmid_empty cyc %0d: en=%b rv=%b rr=%b, want 0 0 1",
                         i, mst_en, rsp_valid, req_ready);
            end
            tick();
        end
        a = mk(1'b0, 15'h5, '0, 4'hF, 1, $urandom());
        push_one(a, ok);
        wait_rsp(ok);
        n_tests++;
        if (!ok || rsp_err !== 1'b0 || rsp_rdata !== a.rdata) begin
            n_fail++;
            $display("FAIL rstmid_after: seen=%b err=%b rd=%h, want 1 0 %h",
                     ok, rsp_err, rsp_rdata, a.rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin : guard
        #600000;
        $display("FAIL global_timeout: bench did not finish in time");
        $fatal(1, "global timeout");
    end

    initial begin : main
        srst = 1'b1;
        req_valid = 1'b0;
        req_wr = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        req_strb = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_unmapped();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/friscv_io_master.md
# friscv_io_master

Initiator for the core's IO bus: accepts load/store requests from the load/store unit on a valid/ready stream, buffers them in a small FIFO, and drives them one at a time onto the `mst_*` request/ready interface consumed by the IO interfaces interconnect (GPIO, UART, ...). It returns one response per request, with read data or an error flag. A watchdog terminates accesses that are never acknowledged, such as accesses to unmapped space.

## Interface
- `ADDRW`, 15, IO bus address width
- `XLEN`, 32, data width; strobe width is `XLEN/8`
- `DEPTH`, 4, request FIFO depth; power of 2, at least 2
- `TIMEOUT`, 64, maximum number of cycles `mst_en` is held for one access; at least 2

Ports:
- `aclk` in 1 clock
- `srst` in 1 synchronous active-high reset
- `req_valid` in 1 request valid
- `req_ready` out 1 request accepted when both high at `aclk` edge
- `req_wr` in 1 1 = write, 0 = read
- `req_addr` in ADDRW request address
- `req_wdata` in XLEN write data
- `req_strb` in XLEN/8 byte strobes
- `rsp_valid` out 1 response valid
- `rsp_ready` in 1 response consumed
- `rsp_rdata` out XLEN read data; 0 for writes and errors
- `rsp_err` out 1 access timed out
- `mst_en` out 1 access request
- `mst_wr` out 1 access direction
- `mst_addr` out ADDRW access address
- `mst_wdata` out XLEN access write data
- `mst_strb` out XLEN/8 access strobes
- `mst_rdata` in XLEN read data, valid when `mst_ready` is high
- `mst_ready` in 1 access completes at the edge where `mst_en` and `mst_ready` are both high

## Operation
- **Request FIFO**
  - Entry = {wr, addr, wdata, strb}.
  - `req_ready` = not full, and 0 while `srst` is high.
  - No push-while-full lookahead: a full FIFO deasserts `req_ready` even if a pop happens in the same cycle.
- **FSM states:** IDLE, ACCESS, RESP.
- **IDLE**
  - If the FIFO is not empty: register the head entry onto the `mst_*` outputs, set `mst_en`=1, clear the watchdog, go to ACCESS.
- **ACCESS**
  - `mst_en`, `mst_wr`, `mst_addr`, `mst_wdata` and `mst_strb` stay stable.
  - On an edge with `mst_ready`=1:
    - `rsp_rdata` captures `mst_rdata` for reads, 0 for writes.
    - `rsp_err`=0, pop the FIFO, `mst_en`=0, go to RESP.
  - Otherwise the watchdog increments.
  - When the watchdog equals `TIMEOUT-1` and `mst_ready`=0:
    - `rsp_err`=1, `rsp_rdata`=0, pop, `mst_en`=0, go to RESP.
  - If ready and the timeout occur in the same cycle, ready wins.
- **RESP**
  - `rsp_valid`=1, with rdata/err held stable until `rsp_ready`=1 at an edge, then go to IDLE.
- **Ordering:** one outstanding access; responses are returned in request order.
- **Watchdog:** width `$clog2(TIMEOUT)`; no wrap, since it is cleared on each new access.
- **Reset values:** `mst_en`, `mst_wr`, `mst_addr`, `mst_wdata`, `mst_strb`, `rsp_valid`, `rsp_rdata`, `rsp_err` = 0; `req_ready`=0 during reset; FSM in IDLE; FIFO empty.
- **Reset mid-operation:**
  - The in-flight access is abandoned and `mst_en` drops at the reset edge.
  - Buffered requests are discarded and no response is issued.

## Timing
- Request accepted at edge N → FIFO non-empty in cycle N+1 → `mst_en`=1 from edge N+2.
- Ready sampled at edge M → `mst_en`=0 and `rsp_valid`=1 from edge M.
- Response handshake at edge R → IDLE in cycle R+1 → next `mst_en` no earlier than edge R+2. `mst_en` is therefore low for at least 2 cycles between accesses.
- Timeout: `mst_en` is high for exactly `TIMEOUT` cycles, then `rsp_valid`=1 with `rsp_err`=1.
- Zero-wait responder (ready already high): access lasts 1 cycle.
- Throughput with `rsp_ready` tied high and a zero-wait responder: 1 access per 3 cycles.
- All outputs are registered except `req_ready` (derived from FIFO flags).

## Structure
- Package `friscv_io_master_pkg`:
  - FSM state enum (IDLE/ACCESS/RESP).
  - Packed struct for the FIFO entry, parameterized by `ADDRW`/`XLEN` via localparam widths.
- Sub-module `friscv_io_req_fifo`: synchronous single-clock FIFO (push/pop, full/empty, `srst`), pointers one bit wider than `$clog2(DEPTH)` for full/empty detection.
- Top holds the FSM, output registers, and watchdog.

## Test plan
- **Reset:** hold `srst` 5 cycles with `req_valid`=1 → `mst_en`=0, `rsp_valid`=0, `req_ready`=0 throughout; `req_ready`=1 the cycle after release.
- **Write:** write `addr`=0, `wdata`=32'h09876543, `strb`=4'hF; responder raises ready after 3 cycles →
  - `mst_*` stable for 4 cycles;
  - one response with `rsp_err`=0, `rsp_rdata`=0;
  - `mst_en` rises exactly 2 cycles after acceptance.
- **Read:** read `addr`=1; responder returns 32'ha5a5a5a5 with zero wait → `rsp_rdata`=32'ha5a5a5a5, `rsp_err`=0.
- **Unmapped:** read `addr`=15'h1000; responder never raises ready → `mst_en` high exactly 64 cycles, then `rsp_err`=1, `rsp_rdata`=0. The next queued request still completes normally.
- **Backpressure:**
  - Push 6 requests back-to-back with `rsp_ready`=0 → `req_ready` drops after 4 accepted.
  - Releasing `rsp_ready` yields responses in order with addresses matching, and the remaining 2 requests are accepted.
- **Reset mid-access:** assert `srst` during ACCESS with 2 entries queued → `mst_en`=0 next cycle, no response, FIFO empty, and a new request afterwards works.
